// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined ADD/SUB/CMP/ADC unit, one CHUNK-bit carry-lookahead slice per stage.
// Define ADDSUB_PIPE_UCMP_EN to add the in_unsigned port for unsigned compares.
module addsub_pipe #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef ADDSUB_PIPE_UCMP_EN
   input  logic             in_unsigned,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_op,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             eq_flag,
   output logic             gt_flag,
   output logic             c_flag
);

   localparam int NSTAGE = WIDTH / CHUNK;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b10;
   localparam logic [1:0] OP_ADC = 2'b11;

   // ar_* holds finished result slices below the current slice and unprocessed A slices above it
   logic [NSTAGE-1:0]            vld_q, vld_d, cy_q, cy_d;
   logic [NSTAGE-1:0][1:0]       op_q, op_d;
   logic [NSTAGE-1:0][WIDTH-1:0] ar_q, ar_d, br_q, br_d;
   logic [NSTAGE-1:0]            src_v, src_c;
   logic [NSTAGE-1:0][1:0]       src_op;
   logic [NSTAGE-1:0][WIDTH-1:0] src_a, src_b;
   logic                         ovf_q, ovf_d;
   logic                         eq_q, eq_d, gt_q, gt_d, c_q, c_d;
   logic                         advance, xfer, is_sub, res_zero, gt_cmp;
   logic [CHUNK:0]               slice;
   logic                         unused_br;
`ifdef ADDSUB_PIPE_UCMP_EN
   logic [NSTAGE-1:0]            uns_q, uns_d, src_u;
`endif

   function automatic logic [CHUNK:0] cla_add(input logic [CHUNK-1:0] a,
                                              input logic [CHUNK-1:0] b,
                                              input logic             cin);
      logic [CHUNK-1:0] g, p;
      logic [CHUNK:0]   c;
      logic             pp;
      g = a & b;
      p = a ^ b;
      c = '0;
      for (int i = 0; i <= CHUNK; i++) begin
         pp = 1'b1;
         for (int j = CHUNK-1; j >= 0; j--) begin
            if (j < i) begin
               c[i] = c[i] | (pp & g[j]);
               pp   = pp & p[j];
            end
         end
         c[i] = c[i] | (pp & cin);
      end
      return {c[CHUNK], p ^ c[CHUNK-1:0]};
   endfunction

   assign advance    = !vld_q[NSTAGE-1] || out_ready;
   assign xfer       = vld_q[NSTAGE-1] && out_ready;
   assign in_ready   = advance;
   assign out_valid  = vld_q[NSTAGE-1];
   assign out_op     = op_q[NSTAGE-1];
   assign out_result = ar_q[NSTAGE-1];
   assign out_cout   = cy_q[NSTAGE-1];
   assign out_ovf    = ovf_q;
   assign eq_flag    = eq_q;
   assign gt_flag    = gt_q;
   assign c_flag     = c_q;
   // The last stage's copy of B has no consumer once the MSB slice is done.
   assign unused_br  = ^br_q[NSTAGE-1];

   always_comb begin
      is_sub    = (in_op == OP_SUB) || (in_op == OP_CMP);
      src_v[0]  = in_valid;
      src_op[0] = in_op;
      src_a[0]  = in_a;
      src_b[0]  = is_sub ? ~in_b : in_b;
      src_c[0]  = is_sub | ((in_op == OP_ADC) & c_q);
`ifdef ADDSUB_PIPE_UCMP_EN
      src_u[0]  = in_unsigned;
`endif
      for (int k = 1; k < NSTAGE; k++) begin
         src_v[k]  = vld_q[k-1];
         src_op[k] = op_q[k-1];
         src_a[k]  = ar_q[k-1];
         src_b[k]  = br_q[k-1];
         src_c[k]  = cy_q[k-1];
`ifdef ADDSUB_PIPE_UCMP_EN
         src_u[k]  = uns_q[k-1];
`endif
      end
      slice = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         slice    = cla_add(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK], src_c[k]);
         vld_d[k] = src_v[k];
         op_d[k]  = src_op[k];
         cy_d[k]  = slice[CHUNK];
         ar_d[k]  = src_a[k];
         ar_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
         br_d[k]  = src_b[k];
`ifdef ADDSUB_PIPE_UCMP_EN
         uns_d[k] = src_u[k];
`endif
      end
      ovf_d = (src_a[NSTAGE-1][WIDTH-1] == src_b[NSTAGE-1][WIDTH-1]) &&
              (ar_d[NSTAGE-1][WIDTH-1] != src_a[NSTAGE-1][WIDTH-1]);
   end

   always_comb begin
      res_zero = (ar_q[NSTAGE-1] == '0);
`ifdef ADDSUB_PIPE_UCMP_EN
      gt_cmp = uns_q[NSTAGE-1] ? (cy_q[NSTAGE-1] && !res_zero)
                               : (!res_zero && (ar_q[NSTAGE-1][WIDTH-1] == ovf_q));
`else
      gt_cmp = !res_zero && (ar_q[NSTAGE-1][WIDTH-1] == ovf_q);
`endif
      eq_d = eq_q;
      gt_d = gt_q;
      c_d  = c_q;
      // Flags commit only when the consumer takes the result.
      if (xfer) begin
         c_d = cy_q[NSTAGE-1];
         if (op_q[NSTAGE-1] == OP_CMP) begin
            eq_d = res_zero;
            gt_d = gt_cmp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         op_q  <= '0;
         cy_q  <= '0;
         ar_q  <= '0;
         br_q  <= '0;
         ovf_q <= 1'b0;
         eq_q  <= 1'b0;
         gt_q  <= 1'b0;
         c_q   <= 1'b0;
`ifdef ADDSUB_PIPE_UCMP_EN
         uns_q <= '0;
`endif
      end else begin
         if (advance) begin
            vld_q <= vld_d;
            op_q  <= op_d;
            cy_q  <= cy_d;
            ar_q  <= ar_d;
            br_q  <= br_d;
            ovf_q <= ovf_d;
`ifdef ADDSUB_PIPE_UCMP_EN
            uns_q <= uns_d;
`endif
         end
         eq_q <= eq_d;
         gt_q <= gt_d;
         c_q  <= c_d;
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (WIDTH 32, CHUNK 8).
module tb_addsub_pipe;
   localparam int W = 32;
   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, CMP = 2'b10, ADC = 2'b11;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, out_valid, out_ready;
   logic         out_cout, out_ovf, eq_flag, gt_flag, c_flag;
   logic [1:0]   in_op, out_op;
   logic [W-1:0] in_a, in_b, out_result;
`ifdef ADDSUB_PIPE_UCMP_EN
   logic         in_unsigned;
`endif
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
`ifdef ADDSUB_PIPE_UCMP_EN
      .in_unsigned(in_unsigned),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_result(out_result), .out_cout(out_cout), .out_ovf(out_ovf),
      .eq_flag(eq_flag), .gt_flag(gt_flag), .c_flag(c_flag)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op into an empty pipe and wait for its result to be presented.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, 4);
   endtask

   initial begin
`ifdef ADDSUB_PIPE_UCMP_EN
      in_unsigned = 1'b0;
`endif
      // reset held with an op offered: it must not be accepted
      reset = 1'b1; in_valid = 1'b1; in_op = ADD; in_a = 1; in_b = 1; out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0; in_valid = 1'b0;
      check("rst out_valid", out_valid, 0);
      check("rst out_result", out_result, 0);
      check("rst flags", {eq_flag, gt_flag, c_flag}, 0);
      check("rst in_ready", in_ready, 1);
      repeat (5) tick();
      check("rst op not accepted", out_valid, 0);

      run_op("add", ADD, 5, 7);
      check("add result", out_result, 12);
      check("add cout/ovf", {out_cout, out_ovf}, 0);
      check("add op", out_op, ADD);
      tick();
      check("add c_flag", c_flag, 0);
      check("add drained", out_valid, 0);

      run_op("cmp max", CMP, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      check("cmp max diff", out_result, 32'h8000_0000);
      check("cmp max ovf", out_ovf, 1);
      check("cmp max op", out_op, CMP);
      check("cmp max flags before xfer", {eq_flag, gt_flag, c_flag}, 3'b000);
      tick();
      check("cmp max flags", {eq_flag, gt_flag, c_flag}, 3'b010);

      run_op("cmp -1v1", CMP, 32'hFFFF_FFFF, 1);
      check("cmp -1v1 diff", out_result, 32'hFFFF_FFFE);
      tick();
      check("cmp -1v1 flags", {eq_flag, gt_flag, c_flag}, 3'b001);

      run_op("cmp eq", CMP, 42, 42);
      check("cmp eq diff", out_result, 0);
      tick();
      check("cmp eq flags", {eq_flag, gt_flag, c_flag}, 3'b101);

      run_op("sub", SUB, 3, 5);
      check("sub result", out_result, 32'hFFFF_FFFE);
      check("sub cout/ovf", {out_cout, out_ovf}, 0);
      tick();
      check("sub flags", {eq_flag, gt_flag, c_flag}, 3'b100);

      run_op("add carry", ADD, 32'hFFFF_FFFF, 1);
      check("add carry result", out_result, 0);
      check("add carry cout/ovf", {out_cout, out_ovf}, 2'b10);
      tick();
      check("add carry flags", {eq_flag, gt_flag, c_flag}, 3'b101);

      run_op("adc", ADC, 0, 0);
      check("adc result", out_result, 1);
      tick();
      check("adc flags", {eq_flag, gt_flag, c_flag}, 3'b100);

      // ADC right behind a carry-producing ADD must see the old c_flag
      in_valid = 1'b1; in_op = ADD; in_a = 32'hFFFF_FFFF; in_b = 1;
      tick();
      in_op = ADC; in_a = 0; in_b = 0;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      check("fwd add valid", out_valid, 1);
      check("fwd add result", {out_op, out_cout, out_result}, {ADD, 1'b1, 32'h0});
      tick();
      check("fwd c_flag set", c_flag, 1);
      check("fwd adc valid", out_valid, 1);
      check("fwd adc result", {out_op, out_result}, {ADC, 32'h0});
      tick();
      check("fwd c_flag after adc", c_flag, 0);
      check("fwd drained", out_valid, 0);

      begin : bp
         int   sent, recv, cyc;
         logic acc;
         sent = 0; recv = 0; cyc = 0;
         while (recv < 8 && cyc < 200) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            #1;
            if (out_valid) begin
               check("bp order", out_result, 100 + recv);
               if (out_ready) recv++;
               else check("bp in_ready stall", in_ready, 0);
            end
            if (sent < 8) begin
               in_valid = 1'b1; in_op = ADD; in_a = sent; in_b = 100;
            end else begin
               in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            cyc++;
         end
         in_valid = 1'b0; out_ready = 1'b1;
         check("bp received", recv, 8);
         check("bp sent", sent, 8);
         repeat (3) tick();
         check("bp no duplicate", out_valid, 0);
      end

      run_op("cmp 5v3", CMP, 5, 3);
      check("cmp 5v3 diff", out_result, 2);
      tick();
      check("cmp 5v3 flags", {eq_flag, gt_flag, c_flag}, 3'b011);

      // reset with three ops in flight
      in_valid = 1'b1; in_op = ADD;
      in_a = 32'h7FFF_FFFF; in_b = 1; tick();
      in_a = 1; in_b = 1; tick();
      in_a = 2; in_b = 2; tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid rst outputs", {out_valid, out_op, out_cout, out_ovf}, 0);
      check("mid rst result", out_result, 0);
      check("mid rst flags", {eq_flag, gt_flag, c_flag}, 0);
      check("mid rst in_ready", in_ready, 1);
      begin : drain
         logic seen;
         seen = 1'b0;
         repeat (6) begin
            tick();
            seen = seen | out_valid;
         end
         check("mid rst no stale valid", seen, 0);
      end
      run_op("post rst add", ADD, 2, 3);
      check("post rst result", out_result, 5);
      tick();

`ifdef ADDSUB_PIPE_UCMP_EN
      in_unsigned = 1'b1;
      run_op("ucmp", CMP, 32'hFFFF_FFFF, 1);
      in_unsigned = 1'b0;
      check("ucmp diff", out_result, 32'hFFFF_FFFE);
      tick();
      check("ucmp flags", {eq_flag, gt_flag, c_flag}, 3'b011);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined add/subtract/compare unit and the next generation of the processor's integer adder datapath. A WIDTH-bit operation is split into CHUNK-bit carry-lookahead slices, one slice per pipeline stage, with the carry registered between stages. Operands enter through a valid/ready handshake and results leave through one. An internal flag register holds Eq/Gt (signed compare with overflow correction) and a carry flag that ADC consumes.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 8, slice width; NSTAGE = WIDTH/CHUNK pipeline stages
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset; synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  2  00 ADD, 01 SUB, 10 CMP, 11 ADC (A+B+c_flag)
- in_a, in_b  in  WIDTH  operands
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_op  out  2  op of the presented result
- out_result  out  WIDTH  sum, or difference for SUB/CMP (always driven, never Z)
- out_cout  out  1  carry out of MSB slice
- out_ovf  out  1  signed overflow
- eq_flag, gt_flag, c_flag  out  1 each  architectural flags

## Operation
- Operand conditioning at acceptance: SUB/CMP use ~B with carry-in 1. ADD uses B with carry-in 0. ADC uses B with carry-in = c_flag sampled in the acceptance cycle.
- No forwarding: an ADC accepted while a flag-writing op is in flight sees the old c_flag.
- Stage k (0..NSTAGE-1) computes slice k with CHUNK-bit carry lookahead using the registered carry from stage k-1.
- Unprocessed operand slices and finished result slices travel skewed with the op, so every stage register carries one full operation.
- Overflow: ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the conditioned B.
- Compare: eq = (diff == 0); gt = !eq && (diff[MSB] == ovf). This is a signed compare.
- Flag writes happen only on the output transfer (out_valid && out_ready):
  - CMP writes eq_flag, gt_flag and c_flag = out_cout.
  - ADD, SUB and ADC write only c_flag.
  - Flags never change on acceptance or while a result is stalled.
- Stall: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance is 0, every stage register holds its value. This includes bubbles, so the pipeline does not compress.
- Reset: all stage valid bits cleared, in-flight ops discarded, and out_valid, out_result, out_cout, out_ovf, out_op, eq_flag, gt_flag, c_flag all set to 0. in_ready = 1 in the first cycle after reset.
- reset asserted together with in_valid: the op is not accepted.

## Timing
- Latency: an op accepted at edge T has out_valid = 1 after edge T+NSTAGE-1 (4 cycles total for 32/8), provided there is no stall.
- Throughput: one op per cycle while out_ready = 1.
- Flags are visible in the cycle after the transfer edge.
- Back-to-back CMPs update flags in transfer order.
- Output handshake: while out_valid = 1 and out_ready = 0, out_* stays stable.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid.
- NSTAGE = 1 (CHUNK = WIDTH) is legal and gives single-cycle latency.

## Configuration
- ADDSUB_PIPE_UCMP_EN defined:
  - Adds input port in_unsigned (1 bit), sampled with the op and carried down the pipeline.
  - For CMP with in_unsigned = 1: gt = out_cout && !eq.
- Macro undefined: the port is absent and all compares are signed.
- Arithmetic results, out_ovf and out_cout are unaffected in both builds.

## Test plan
- ADD 5 + 7, out_ready = 1: out_result = 12, cout = 0, ovf = 0, out_valid exactly 4 cycles after acceptance; c_flag = 0.
- SUB 3 - 5: out_result = 0xFFFFFFFE, cout = 0; then CMP 0x7FFFFFFF vs 0xFFFFFFFF: diff = 0x80000000, ovf = 1, gt_flag = 1, eq_flag = 0.
- CMP 42 vs 42 gives eq = 1, gt = 0; CMP -1 vs 1 gives eq = 0, gt = 0. In the UCMP build, CMP 0xFFFFFFFF vs 1 unsigned gives gt = 1.
- Carry chain, ADC: ADD 0xFFFFFFFF + 1 gives result 0, c_flag = 1. Let it drain, then ADC 0 + 0 gives result 1.
- Back-pressure, stream of 8 ADDs:
  - out_ready low for 5 cycles: in_ready drops with out_valid, outputs stay stable, all 8 results arrive in order with no loss or duplication.
- Reset asserted with 3 ops in flight: all outputs 0 the next cycle, no stale out_valid, flags 0, and a new op completes normally.
